// File: rtl/sum_pkg.sv
// ---------------------------------------------------------------------------
// sum_pkg
// Definitions shared by the sum/difference calculator and its display path.
//   state_t      : controller states (IDLE, CALC, CONV, DONE)
//   OP_ADD/OP_SUB: encodings of the op input
//   CONV_CYCLES  : number of double-dabble iterations (one per binary bit)
//   SEG7_TABLE   : active-low {g,f,e,d,c,b,a} patterns for digits 0..9
//   dd_step()    : one double-dabble iteration on the packed BCD/binary word
// ---------------------------------------------------------------------------
package sum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_CONV = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // The magnitude is 5 bits wide (max 30), so five shift steps.
    localparam int CONV_CYCLES = 5;

    // Double-dabble word: {tens nibble, units nibble, 5-bit binary}.
    localparam int DD_W = 13;

    localparam logic [6:0] SEG7_BLANK = 7'h7F;

    // Index 0 is the leftmost element of the concatenation.
    localparam logic [0:9][6:0] SEG7_TABLE = {
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    // Add 3 to each BCD nibble that is 5 or more, then shift left by one.
    function automatic logic [DD_W-1:0] dd_step(input logic [DD_W-1:0] s);
        logic [DD_W-1:0] t;
        t = s;
        if (t[8:5] >= 4'd5) begin
            t[8:5] = t[8:5] + 4'd3;
        end
        if (t[12:9] >= 4'd5) begin
            t[12:9] = t[12:9] + 4'd3;
        end
        return {t[DD_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/sum_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// sum_seq_ctrl_if
// Request/result bundle of the calculator.
//   a, b, op, start : request side, driven by the master
//   busy, done, neg : status, driven by the calculator
//   tens, units     : BCD result digits
//   an, seg         : multiplexed 2-digit 7-segment drive (active-low)
// ---------------------------------------------------------------------------
interface sum_seq_ctrl_if;
    logic [3:0] a;
    logic [3:0] b;
    logic       op;
    logic       start;
    logic       busy;
    logic       done;
    logic       neg;
    logic [1:0] tens;
    logic [3:0] units;
    logic [1:0] an;
    logic [6:0] seg;

    modport master (
        output a, b, op, start,
        input  busy, done, neg, tens, units, an, seg
    );

    modport slave (
        input  a, b, op, start,
        output busy, done, neg, tens, units, an, seg
    );
endinterface

// File: rtl/bcd_seg7.sv
// ---------------------------------------------------------------------------
// bcd_seg7
// Combinational BCD digit to active-low 7-segment decoder.
//   bcd_i : 4-bit digit; 10..15 produce a blank display
//   seg_o : {g,f,e,d,c,b,a}, active-low
// ---------------------------------------------------------------------------
module bcd_seg7
    import sum_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG7_BLANK;
        if (bcd_i < 4'd10) begin
            seg_o = SEG7_TABLE[bcd_i];
        end
    end

endmodule

// File: rtl/sum_seq_ctrl.sv
// ---------------------------------------------------------------------------
// sum_seq_ctrl
// Sequential 4-bit add / absolute-difference unit with BCD conversion and a
// two-digit multiplexed 7-segment display.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : request (a, b, op, start) and result/status/display signals
// A request is latched in IDLE, the magnitude is formed in CALC, converted
// to BCD over five CONV cycles, and published with a one-cycle done pulse.
// The display scan runs freely, independent of the controller.
// ---------------------------------------------------------------------------
module sum_seq_ctrl
    import sum_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic         clk,
    input  logic         rst_n,
    sum_seq_ctrl_if.slave bus
);

    localparam int               CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [2:0]       CONV_LAST = 3'(CONV_CYCLES - 1);

    state_t            state_q, state_d;
    logic [3:0]        a_q, b_q;
    logic              op_q;
    logic [DD_W-1:0]   shift_q, dd_next;
    logic [2:0]        bit_cnt_q;
    logic [1:0]        tens_q;
    logic [3:0]        units_q;
    logic              neg_q;
    logic [CNT_W-1:0]  scan_q;
    logic [1:0]        an_q;
    logic [4:0]        mag;
    logic              conv_last;
    logic [3:0]        disp_digit;

    assign conv_last = (bit_cnt_q == CONV_LAST);
    assign dd_next   = dd_step(shift_q);

    always_comb begin
        mag = {1'b0, a_q} + {1'b0, b_q};
        if (op_q == OP_SUB) begin
            if (a_q >= b_q) begin
                mag = {1'b0, a_q - b_q};
            end else begin
                mag = {1'b0, b_q - a_q};
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_CALC;
            ST_CALC: state_d = ST_CONV;
            ST_CONV: if (conv_last) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus.busy = (state_q != ST_IDLE);
        bus.done = (state_q == ST_DONE);
    end

    // Datapath: operand capture, magnitude load, double-dabble, result publish
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= OP_ADD;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tens_q    <= '0;
            units_q   <= '0;
            neg_q     <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_q  <= bus.a;
                        b_q  <= bus.b;
                        op_q <= bus.op;
                    end
                end
                ST_CALC: begin
                    shift_q   <= {8'd0, mag};
                    bit_cnt_q <= '0;
                end
                ST_CONV: begin
                    shift_q   <= dd_next;
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    // Publish on the same edge that enters DONE.
                    if (conv_last) begin
                        tens_q  <= dd_next[10:9];
                        units_q <= dd_next[8:5];
                        neg_q   <= (op_q == OP_SUB) && (b_q > a_q);
                    end
                end
                default: ;
            endcase
        end
    end

    // Display scan: free-running dwell counter, digit enable flips on wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_q <= '0;
            an_q   <= 2'b10;
        end else if (scan_q == SCAN_LAST) begin
            scan_q <= '0;
            an_q   <= ~an_q;
        end else begin
            scan_q <= scan_q + 1'b1;
        end
    end

    // an = 2'b01 enables the tens digit; otherwise the units digit is shown.
    assign disp_digit = (an_q == 2'b01) ? {2'b00, tens_q} : units_q;

    bcd_seg7 u_seg7 (
        .bcd_i (disp_digit),
        .seg_o (bus.seg)
    );

    assign bus.tens  = tens_q;
    assign bus.units = units_q;
    assign bus.neg   = neg_q;
    assign bus.an    = an_q;

endmodule
